// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its controller/register file.
// The master drives enable, count-strobe selection and the pin; the slave returns results.
interface pwm_capture_if #(
  parameter int COMPARE_SIZE = 8
) ();
  logic                    ena;
  logic                    use_sys;
  logic                    tick_in;
  logic                    pwm_in;
  logic [COMPARE_SIZE-1:0] duty_out;
  logic [COMPARE_SIZE:0]   period_out;
  logic                    valid;
  logic                    stuck_high;
  logic                    stuck_low;

  modport master (
    output ena, use_sys, tick_in, pwm_in,
    input  duty_out, period_out, valid, stuck_high, stuck_low
  );

  modport slave (
    input  ena, use_sys, tick_in, pwm_in,
    output duty_out, period_out, valid, stuck_high, stuck_low
  );
endinterface

// File: rtl/pwm_capture.sv
// Recovers the duty (high-tick count) and period (total-tick count) of an asynchronous PWM input.
// Results and stuck-line flags update together with a one-cycle valid pulse.
module pwm_capture #(
  parameter int COMPARE_SIZE = 8
) (
  input logic          sys_clk,
  input logic          rst,
  pwm_capture_if.slave bus
);
  // state | meaning
  // IDLE  | disabled; counters held at zero
  // ARM   | waiting for the first rising edge; partial period discarded
  // MEAS  | counting a period; each rising edge publishes and restarts
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  localparam int            CW       = COMPARE_SIZE + 1;
  localparam logic [CW-1:0] TMO      = '1;
  localparam logic [CW-1:0] ARM_LAST = TMO - CW'(1);

  logic                    sync_q;
  logic                    lvl;
  logic                    lvl_d;
  logic                    rise;
  logic                    step;
  logic                    publish;
  logic                    timeout;
  logic [1:0]              state;
  logic [CW-1:0]           per_cnt;
  logic [CW-1:0]           hi_cnt;
  logic [COMPARE_SIZE-1:0] duty_q;
  logic [CW-1:0]           period_q;
  logic                    valid_q;
  logic                    stuck_high_q;
  logic                    stuck_low_q;

  assign rise = lvl & ~lvl_d;
  assign step = bus.use_sys | bus.tick_in;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != TMO)) ? v + CW'(1) : v;
  endfunction

  // ARM fires on its TMO-th step; MEAS counts the rise cycle as step one.
  always_comb begin
    publish = 1'b0;
    timeout = 1'b0;
    if (bus.ena) begin
      case (state)
        ARM:  timeout = ~rise & step & (per_cnt == ARM_LAST);
        MEAS: begin
          publish = rise;
          timeout = ~rise & step & (per_cnt == TMO);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      lvl    <= 1'b0;
      lvl_d  <= 1'b0;
    end else begin
      sync_q <= bus.pwm_in;
      lvl    <= sync_q;
      lvl_d  <= lvl;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (!bus.ena) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= ARM;
          per_cnt <= '0;
          hi_cnt  <= '0;
        end
        ARM: begin
          if (rise) begin
            state   <= MEAS;
            per_cnt <= CW'(step);
            hi_cnt  <= CW'(step);
          end else if (timeout) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
          end else begin
            per_cnt <= sat_inc(per_cnt, step);
            hi_cnt  <= '0;
          end
        end
        MEAS: begin
          // The rise cycle is already the first tick of the next period.
          if (rise) begin
            per_cnt <= CW'(step);
            hi_cnt  <= CW'(step);
          end else if (timeout) begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end else begin
            per_cnt <= sat_inc(per_cnt, step);
            hi_cnt  <= sat_inc(hi_cnt, step & lvl);
          end
        end
        default: begin
          state   <= IDLE;
          per_cnt <= '0;
          hi_cnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      valid_q <= publish | timeout;
      if (publish) begin
        duty_q       <= hi_cnt[COMPARE_SIZE] ? '1 : hi_cnt[COMPARE_SIZE-1:0];
        period_q     <= per_cnt;
        stuck_high_q <= 1'b0;
        stuck_low_q  <= 1'b0;
      end else if (timeout) begin
        duty_q       <= {COMPARE_SIZE{lvl}};
        period_q     <= TMO;
        stuck_high_q <= lvl;
        stuck_low_q  <= ~lvl;
      end
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.period_out = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck_high = stuck_high_q;
  assign bus.stuck_low  = stuck_low_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture; expected publishes come from the
// high/low segment lengths driven on the pin.
module tb_pwm_capture;
  localparam int CS = 8;

  logic sys_clk = 1'b0;
  logic rst;

  pwm_capture_if #(.COMPARE_SIZE(CS)) bus ();

  pwm_capture #(.COMPARE_SIZE(CS)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int duty;
    int period;
    int sh;
    int sl;
    int cyc;
    int gap;
  } pub_t;

  pub_t got[$];
  pub_t exp_q[$];
  pub_t mon_p;
  int   hs[$];
  int   ls[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   tick_cnt = 0;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial begin
    bus.tick_in = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      tick_cnt = (tick_cnt + 1) % 4;
      bus.tick_in = (tick_cnt == 0);
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (bus.valid) begin
      mon_p.duty   = int'(bus.duty_out);
      mon_p.period = int'(bus.period_out);
      mon_p.sh     = int'(bus.stuck_high);
      mon_p.sl     = int'(bus.stuck_low);
      mon_p.cyc    = cyc;
      mon_p.gap    = -1;
      got.push_back(mon_p);
    end
  end

  task automatic check(input string tag, input int got_v, input int exp_v);
    total++;
    if (got_v != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic seg(input logic level, input int n);
    bus.pwm_in = level;
    tick(n);
  endtask

  task automatic add_exp(input int d, input int p, input int sh, input int sl, input int gap);
    pub_t e;
    e.duty = d; e.period = p; e.sh = sh; e.sl = sl; e.cyc = 0; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic start_capture();
    bus.ena = 1'b0;
    bus.pwm_in = 1'b0;
    tick(4);
    got.delete();
    exp_q.delete();
    bus.ena = 1'b1;
    en_cyc = cyc;
    tick(10);
  endtask

  // Each period publishes at the next rise; a trailing rise flushes the last one.
  task automatic run_periods(input int unit);
    for (int i = 0; i < hs.size(); i++) begin
      seg(1'b1, hs[i] * unit);
      seg(1'b0, ls[i] * unit);
      add_exp((hs[i] > 255) ? 255 : hs[i], hs[i] + ls[i], 0, 0,
              (i == 0) ? -1 : (hs[i] + ls[i]) * unit);
    end
    seg(1'b1, 6);
    bus.ena = 1'b0;
    tick(2);
    bus.pwm_in = 1'b0;
  endtask

  task automatic compare_pubs(input string tag);
    int n;
    check($sformatf("%s_count", tag), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_duty[%0d]", tag, i), got[i].duty, exp_q[i].duty);
      check($sformatf("%s_period[%0d]", tag, i), got[i].period, exp_q[i].period);
      check($sformatf("%s_sh[%0d]", tag, i), got[i].sh, exp_q[i].sh);
      check($sformatf("%s_sl[%0d]", tag, i), got[i].sl, exp_q[i].sl);
      if (i > 0 && exp_q[i].gap >= 0)
        check($sformatf("%s_gap[%0d]", tag, i), got[i].cyc - got[i-1].cyc, exp_q[i].gap);
    end
  endtask

  initial begin
    int h;
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.use_sys = 1'b1;
    bus.pwm_in = 1'b0;
    tick(3);
    check("rst_duty", bus.duty_out, 0);
    check("rst_period", bus.period_out, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_sh", bus.stuck_high, 0);
    check("rst_sl", bus.stuck_low, 0);
    rst = 1'b0;
    tick(2);

    // 64 high / 192 low
    start_capture();
    hs = '{64, 64, 64, 64};
    ls = '{192, 192, 192, 192};
    run_periods(1);
    compare_pubs("t1");

    // duty saturation and a 511-tick period where the rise beats the timeout
    start_capture();
    hs = '{300, 255, 256, 100};
    ls = '{150, 100, 2, 411};
    run_periods(1);
    compare_pubs("sat");

    // strobe-driven counting, one tick every 4th cycle
    bus.use_sys = 1'b0;
    start_capture();
    hs = '{200, 200, 200};
    ls = '{56, 56, 56};
    run_periods(4);
    compare_pubs("t2");
    bus.use_sys = 1'b1;

    for (int r = 0; r < 3; r++) begin
      start_capture();
      hs.delete();
      ls.delete();
      for (int k = 0; k < 6; k++) begin
        h = $urandom_range(300, 2);
        hs.push_back(h);
        ls.push_back($urandom_range(511 - h, 2));
      end
      run_periods(1);
      compare_pubs($sformatf("rnd%0d", r));
    end

    // held low from ARM: one cycle to leave IDLE, then 511 steps per timeout
    start_capture();
    tick(1090);
    add_exp(0, 511, 0, 1, -1);
    add_exp(0, 511, 0, 1, 511);
    check("t3_first_tmo", (got.size() > 0) ? got[0].cyc - en_cyc : -1, 512);
    check("t3_flag_low", bus.stuck_low, 1);
    check("t3_flag_high", bus.stuck_high, 0);
    hs = '{10, 10};
    ls = '{246, 246};
    run_periods(1);
    compare_pubs("t3");
    check("t3_low_cleared", bus.stuck_low, 0);

    // held high after a rise, then outputs hold while disabled, then 1/255 pulses
    start_capture();
    seg(1'b1, 1200);
    add_exp(255, 511, 1, 0, -1);
    add_exp(255, 511, 1, 0, 511);
    check("t4_flag_high", bus.stuck_high, 1);
    check("t4_duty_full", bus.duty_out, 255);
    bus.ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t4_hold_valid", bus.valid, 0);
      check("t4_hold_sh", bus.stuck_high, 1);
      check("t4_hold_period", bus.period_out, 511);
    end
    bus.ena = 1'b1;
    seg(1'b0, 10);
    hs = '{1, 1, 1};
    ls = '{255, 255, 255};
    run_periods(1);
    compare_pubs("t4");

    // ena dropped mid-high: the torn period is never published
    start_capture();
    seg(1'b1, 64);
    seg(1'b0, 192);
    seg(1'b1, 30);
    add_exp(64, 256, 0, 0, -1);
    bus.ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t5_hold_valid", bus.valid, 0);
      check("t5_hold_duty", bus.duty_out, 64);
      check("t5_hold_period", bus.period_out, 256);
    end
    bus.ena = 1'b1;
    seg(1'b1, 29);
    seg(1'b0, 192);
    hs = '{100, 150};
    ls = '{150, 100};
    run_periods(1);
    compare_pubs("t5");

    // asynchronous reset mid-period, released during a low phase
    start_capture();
    seg(1'b1, 64);
    seg(1'b0, 192);
    seg(1'b1, 20);
    check("t6_pre_duty", bus.duty_out, 64);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_duty", bus.duty_out, 0);
    check("t6_rst_period", bus.period_out, 0);
    check("t6_rst_valid", bus.valid, 0);
    check("t6_rst_sh", bus.stuck_high, 0);
    check("t6_rst_sl", bus.stuck_low, 0);
    tick(1);
    seg(1'b1, 43);
    seg(1'b0, 100);
    rst = 1'b0;
    seg(1'b0, 92);
    got.delete();
    exp_q.delete();
    hs = '{64, 64};
    ls = '{192, 192};
    run_periods(1);
    compare_pubs("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
